// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, sampling constants and divider helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// rtl/uart_rx_buffered_if.sv - receive buffer register-side signals
interface uart_rx_buffered_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rx_pop;
    logic          clr_err;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          frame_err;
    logic          overrun;

    modport master (
        input  rx_pop,
        input  clr_err,
        output rx_data,
        output rx_valid,
        output rx_count,
        output frame_err,
        output overrun
    );

    modport slave (
        output rx_pop,
        output clr_err,
        input  rx_data,
        input  rx_valid,
        input  rx_count,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - show-ahead byte FIFO with extra-MSB pointers
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 16x oversampled 8N1 receiver feeding a byte FIFO
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    uart_rx_buffered_if.master bus
);
    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic             rx_meta;
    logic             rx_s;
    uart_state_t      state;
    uart_state_t      state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       sample_cnt;
    logic             tick;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             s7;
    logic             s8;
    logic             vote;
    logic             vote_done;
    logic             restart;
    logic             shift_en;
    logic             push;
    logic             frame_err_set;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             frame_err_q;
    logic             overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick      = (div_cnt == DIV_W'(DIV - 1));
    assign vote_done = tick && (sample_cnt == SAMPLE_C);
    assign vote      = majority3(s7, s8, rx_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            START: if (vote_done) state_next = vote ? IDLE : DATA;
            DATA:  if (vote_done && (bit_idx == 3'd7)) state_next = STOP;
            // Leaving at mid stop bit lets a back-to-back start edge be caught.
            STOP:  if (vote_done) state_next = vote ? IDLE : BREAK;
            BREAK: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        restart       = 1'b0;
        shift_en      = 1'b0;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            IDLE:    restart       = !rx_s;
            DATA:    shift_en      = vote_done;
            STOP: begin
                push          = vote_done && vote;
                frame_err_set = vote_done && !vote;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            sample_cnt <= '0;
        end else if (restart) begin
            div_cnt    <= '0;
            sample_cnt <= '0;
        end else if (tick) begin
            div_cnt    <= '0;
            sample_cnt <= sample_cnt + 4'd1;
        end else begin
            div_cnt    <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s7        <= 1'b1;
            s8        <= 1'b1;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (tick && (sample_cnt == SAMPLE_A)) s7 <= rx_s;
            if (tick && (sample_cnt == SAMPLE_B)) s8 <= rx_s;
            if (restart) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                shift_reg <= {vote, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop       (bus.rx_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_set;
            if (push && fifo_full && !bus.rx_pop) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = fifo_head;
    assign bus.rx_valid  = !fifo_empty;
    assign bus.rx_count  = fifo_count;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;
    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CLKS   = 160;
    localparam int PUSH_LAT   = 1543;

    logic clk = 1'b0;
    logic reset;
    logic rx;

    uart_rx_buffered_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus();

    uart_rx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_count;
        int         exp_fe;
    } vec_t;

    vec_t       vecs [6];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fe_count = 0;
    int         rise_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q [$];
    logic       exp_ovr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_err) fe_count++;
        if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.rx_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
        else exp_ovr = 1'b1;
    endtask

    task automatic pop_check(input string name);
        check({name, "_valid"}, int'(bus.rx_valid), 1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard actual=empty required=entry", name);
        end else begin
            check({name, "_data"}, int'(bus.rx_data), int'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        bus.rx_pop = 1'b1;
        @(negedge clk);
        bus.rx_pop = 1'b0;
    endtask

    initial begin
        int start_cyc;
        int fe_before;

        vecs[0] = '{data: 8'hA3, stop: 1'b1, exp_count: 1, exp_fe: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_count: 0, exp_fe: 1};
        vecs[2] = '{data: 8'h81, stop: 1'b1, exp_count: 1, exp_fe: 0};
        vecs[3] = '{data: 8'h00, stop: 1'b1, exp_count: 1, exp_fe: 0};
        vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_count: 1, exp_fe: 0};
        vecs[5] = '{data: 8'h6B, stop: 1'b1, exp_count: 1, exp_fe: 0};

        reset = 1'b1;
        rx = 1'b1;
        bus.rx_pop = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(bus.rx_valid), 0);
        check("rst_data", int'(bus.rx_data), 0);
        check("rst_count", int'(bus.rx_count), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        reset = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);

        // Clean 0x55 with latency window
        start_cyc = cyc;
        send_frame(8'h55, 1'b1);
        model_push(8'h55);
        drive_bit(1'b1);
        check("lat_seen", int'(rise_cyc >= start_cyc), 1);
        check("lat_min", int'((rise_cyc - start_cyc) >= PUSH_LAT - 40), 1);
        check("lat_max", int'((rise_cyc - start_cyc) <= PUSH_LAT + 60), 1);
        check("x55_count", int'(bus.rx_count), 1);
        pop_check("x55");
        check("x55_after_valid", int'(bus.rx_valid), 0);
        check("x55_after_data", int'(bus.rx_data), 0);

        // Short low glitch rejected in START
        fe_before = fe_count;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_count", int'(bus.rx_count), 0);
        check("glitch_fe", fe_count - fe_before, 0);

        for (int i = 0; i < 6; i++) begin
            fe_before = fe_count;
            send_frame(vecs[i].data, vecs[i].stop);
            if (vecs[i].stop) begin
                model_push(vecs[i].data);
            end else begin
                drive_bit(1'b0);
                drive_bit(1'b0);
            end
            drive_bit(1'b1);
            check($sformatf("vec%0d_count", i), int'(bus.rx_count), vecs[i].exp_count);
            check($sformatf("vec%0d_fe", i), fe_count - fe_before, vecs[i].exp_fe);
            if (vecs[i].exp_count != 0) begin
                pop_check($sformatf("vec%0d", i));
                check($sformatf("vec%0d_empty", i), int'(bus.rx_valid), 0);
            end
        end

        // Overrun: five frames, no pops
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            model_push(8'(i));
        end
        drive_bit(1'b1);
        check("ovr_count", int'(bus.rx_count), exp_q.size());
        check("ovr_flag", int'(bus.overrun), int'(exp_ovr));
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_pop%0d", i));
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        exp_ovr = 1'b0;
        check("ovr_clr", int'(bus.overrun), 0);

        // Pop lands in the exact push cycle of 0x05 while full
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1);
            model_push(8'(i));
        end
        check("sim_full", int'(bus.rx_count), 4);
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (PUSH_LAT - 1) @(negedge clk);
                check("sim_head", int'(bus.rx_data), int'(exp_q[0]));
                void'(exp_q.pop_front());
                bus.rx_pop = 1'b1;
                @(negedge clk);
                bus.rx_pop = 1'b0;
                check("sim_count_edge", int'(bus.rx_count), 4);
            end
        join
        exp_q.push_back(8'h05);
        drive_bit(1'b1);
        check("sim_count", int'(bus.rx_count), 4);
        check("sim_overrun", int'(bus.overrun), 0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("sim_pop%0d", i));

        // Async reset in data bit 4 of 0xF0 with a byte already buffered
        send_frame(8'h99, 1'b1);
        model_push(8'h99);
        check("prerst_valid", int'(bus.rx_valid), 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        repeat (80) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", int'(bus.rx_valid), 0);
        check("arst_count", int'(bus.rx_count), 0);
        check("arst_data", int'(bus.rx_data), 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("postrst_count", int'(bus.rx_count), 0);
        send_frame(8'h7E, 1'b1);
        model_push(8'h7E);
        drive_bit(1'b1);
        check("x7e_count", int'(bus.rx_count), 1);
        pop_check("x7e");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
